// File: rtl/stream_upsizer_pkg.sv
// Shared helpers for the narrow-to-wide stream upsizer.
package stream_upsizer_pkg;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs NarrowWidth-bit input beats into Ratio-lane words; in_last_i closes a word early.
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int unsigned NarrowWidth = 32,
  parameter int unsigned Ratio       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NarrowWidth-1:0]       in_data_i,
  input  logic                         in_last_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NarrowWidth*Ratio-1:0] out_data_o,
  output logic [Ratio-1:0]             out_strb_o,
  output logic                         out_last_o
);

  localparam int unsigned IdxW  = $clog2(Ratio);
  localparam int unsigned WordW = NarrowWidth * Ratio;

  if (!is_pow2(Ratio) || Ratio < 2) begin : g_bad_ratio
    $error("stream_upsizer: Ratio must be a power of two and at least 2");
  end

  logic [IdxW-1:0]  idx_q;
  logic [WordW-1:0] buf_q;
  logic [Ratio-1:0] mask_q;
  logic             out_valid_q;
  logic [WordW-1:0] out_data_q;
  logic [Ratio-1:0] out_strb_q;
  logic             out_last_q;

  logic             in_hs;
  logic             complete;
  logic [WordW-1:0] buf_next;
  logic [Ratio-1:0] mask_next;

  // The output register is free when empty or being drained this cycle.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign in_hs      = in_valid_i && in_ready_o;
  assign complete   = (idx_q == IdxW'(Ratio - 1)) || in_last_i;

  always_comb begin
    buf_next  = buf_q;
    mask_next = mask_q;
    buf_next[idx_q*NarrowWidth +: NarrowWidth] = in_data_i;
    mask_next[idx_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      buf_q       <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (in_hs) begin
        if (complete) begin
          // Accumulator is cleared after each word, so unfilled lanes read as zero.
          out_data_q <= buf_next;
          out_strb_q <= mask_next;
          out_last_q <= in_last_i;
          buf_q      <= '0;
          mask_q     <= '0;
          idx_q      <= '0;
        end else begin
          buf_q  <= buf_next;
          mask_q <= mask_next;
          idx_q  <= idx_q + IdxW'(1);
        end
      end
      if (in_hs && complete) begin
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer with NarrowWidth=32, Ratio=4.
module tb_stream_upsizer;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   strb;
    logic         last;
  } word_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic         in_last_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] out_data_o;
  logic [3:0]   out_strb_o;
  logic         out_last_o;

  int n_tests = 0;
  int n_fail  = 0;

  word_t        sb[$];
  logic [127:0] m_buf;
  logic [3:0]   m_mask;
  int           m_idx;

  stream_upsizer #(.NarrowWidth(32), .Ratio(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .out_last_o  (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_clear();
    m_buf  = '0;
    m_mask = '0;
    m_idx  = 0;
  endtask

  // Drives one cycle, samples away from the edge and feeds the scoreboard model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic r,
                       output logic ihs, output logic ohs, output logic ov,
                       output logic ir, output word_t obs);
    @(negedge clk_i);
    in_valid_i  = v;
    in_data_i   = d;
    in_last_i   = l;
    out_ready_i = r;
    #1;
    ir  = in_ready_o;
    ov  = out_valid_o;
    ihs = v && in_ready_o;
    ohs = out_valid_o && r;
    obs = '{data: out_data_o, strb: out_strb_o, last: out_last_o};
    if (ihs) begin
      m_buf[m_idx*32 +: 32] = d;
      m_mask[m_idx] = 1'b1;
      if (m_idx == 3 || l) begin
        sb.push_back('{data: m_buf, strb: m_mask, last: l});
        model_clear();
      end else begin
        m_idx++;
      end
    end
    @(posedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;
    model_clear();
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (out_valid_o !== 1'b0 || out_strb_o !== 4'h0 || out_last_o !== 1'b0 || out_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b s=%h l=%b d=%h want all zero",
               out_valid_o, out_strb_o, out_last_o, out_data_o);
    end
    n_tests++;
    if (in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready_o);
    end
    n_tests++;
    if (dut.idx_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idx got=%0d want=0", dut.idx_q);
    end
  endtask

  task automatic test_full_word();
    logic ihs, ohs, ov, ir;
    word_t obs, exp;
    logic [31:0] beats [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) cycle(1'b1, beats[i], 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    n_tests++;
    if (!ohs || sb.size() == 0) begin
      n_fail++;
      $display("FAIL full_word_latency got valid=%b queued=%0d want valid=1", ov, sb.size());
    end else begin
      exp = sb.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL full_word_sb got=%h want=%h", obs, exp);
      end
    end
    n_tests++;
    if (obs !== word_t'{128'h00000044_00000033_00000022_00000011, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL full_word_literal got=%h strb=%b last=%b", obs.data, obs.strb, obs.last);
    end
  endtask

  task automatic test_early_last();
    logic ihs, ohs, ov, ir;
    word_t obs, exp;
    cycle(1'b1, 32'hA, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    cycle(1'b1, 32'hB, 1'b1, 1'b1, ihs, ohs, ov, ir, obs);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    n_tests++;
    if (!ohs || sb.size() == 0) begin
      n_fail++;
      $display("FAIL early_last_valid got valid=%b want=1", ov);
    end else begin
      exp = sb.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL early_last_sb got=%h want=%h", obs, exp);
      end
    end
    n_tests++;
    if (obs !== word_t'{128'h0000000B_0000000A, 4'b0011, 1'b1}) begin
      n_fail++;
      $display("FAIL early_last_literal got=%h strb=%b last=%b", obs.data, obs.strb, obs.last);
    end
    n_tests++;
    if (dut.idx_q !== 2'd0) begin
      n_fail++;
      $display("FAIL early_last_idx got=%0d want=0", dut.idx_q);
    end
    // Single-beat word on lane 0.
    cycle(1'b1, 32'hC, 1'b1, 1'b1, ihs, ohs, ov, ir, obs);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    n_tests++;
    if (obs !== word_t'{128'h0000000C, 4'b0001, 1'b1} || !ov) begin
      n_fail++;
      $display("FAIL lane0_last got=%h strb=%b last=%b valid=%b", obs.data, obs.strb, obs.last, ov);
    end
    if (ohs && sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_backpressure();
    logic ihs, ohs, ov, ir;
    word_t obs, exp, held;
    int sent = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 32'h100 + sent, 1'b0, 1'b0, ihs, ohs, ov, ir, obs);
      if (ihs) sent++;
      if (c == 4) held = obs;
    end
    n_tests++;
    if (sent != 4 || ir !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_in_ready got accepted=%0d ready=%b want accepted=4 ready=0", sent, ir);
    end
    n_tests++;
    if (obs !== held || !ov) begin
      n_fail++;
      $display("FAIL stall_stable got=%h want=%h", obs, held);
    end
    for (int c = 0; c < 40 && (sent < 8 || sb.size() != 0); c++) begin
      cycle(sent < 8, 32'h100 + sent, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
      if (ihs) sent++;
      if (ohs) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stall_extra_word got=%h want none", obs);
        end else begin
          exp = sb.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL stall_sb got=%h want=%h", obs, exp);
          end
        end
      end
    end
    n_tests++;
    if (sent != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain got accepted=%0d pending=%0d want 8/0", sent, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic ihs, ohs, ov, ir;
    word_t obs, exp;
    int words = 0;
    int not_ready = 0;
    for (int c = 0; c < 66; c++) begin
      cycle(c < 64, 32'hB000 + c, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
      if (ir !== 1'b1) not_ready++;
      if (ohs) begin
        words++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_word got=%h want none", obs);
        end else begin
          exp = sb.pop_front();
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_sb got=%h want=%h", obs, exp);
          end
        end
      end
    end
    n_tests++;
    if (words != 16 || not_ready != 0) begin
      n_fail++;
      $display("FAIL b2b_rate got words=%0d stalls=%0d want 16/0", words, not_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic ihs, ohs, ov, ir;
    word_t obs;
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    n_tests++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_valid got=%b want=0", ov);
    end
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
    n_tests++;
    if (!ov || obs !== word_t'{128'h00000004_00000003_00000002_00000001, 4'b1111, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_word got valid=%b data=%h strb=%b", ov, obs.data, obs.strb);
    end
    if (ohs && sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_random();
    logic ihs, ohs, ov, ir, r, l;
    word_t obs, exp, held;
    logic held_v = 1'b0;
    logic [31:0] d = $urandom;
    int sent = 0;
    int bad = 0;
    l = ($urandom_range(5) == 0);
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      r = ($urandom_range(9) < 7);
      cycle($urandom_range(9) < 7, d, l, r, ihs, ohs, ov, ir, obs);
      if (held_v && (!ov || obs !== held)) begin
        bad++;
        if (bad < 5) $display("FAIL rand_stable got=%h want=%h", obs, held);
      end
      held_v = ov && !r;
      held   = obs;
      if (ihs) begin
        sent++;
        d = $urandom;
        l = ($urandom_range(5) == 0);
      end
      if (ohs) begin
        if (sb.size() == 0) begin
          bad++;
          if (bad < 5) $display("FAIL rand_extra_word got=%h want none", obs);
        end else begin
          exp = sb.pop_front();
          if (obs !== exp) begin
            bad++;
            if (bad < 5) $display("FAIL rand_sb got=%h want=%h", obs, exp);
          end
        end
      end
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, ihs, ohs, ov, ir, obs);
      if (ohs) begin
        exp = sb.pop_front();
        if (obs !== exp) begin
          bad++;
          $display("FAIL rand_drain got=%h want=%h", obs, exp);
        end
      end
    end
    n_tests++;
    if (bad != 0 || sent != 10000 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_summary got errors=%0d beats=%0d pending=%0d want 0/10000/0",
               bad, sent, sb.size());
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;
    model_clear();
    test_reset();
    test_full_word();
    test_early_last();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
